spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
Parametrised SPI master for the soft-processor peripheral bus. It supports configurable word width, a programmable SCLK divider, all four CPOL/CPHA modes, MSB- or LSB-first shifting, and multiple chip selects with optional CS hold for multi-word frames. The CPU-facing side is a start/busy/done handshake; the pin side is sclk, mosi, miso and cs_n.

Parameters:
DATA_WIDTH, 8, bits per transfer; legal range 2..32.
DIV_WIDTH, 8, width of the clock_div input.
NUM_CS, 1, number of active-low chip selects; legal range 1..8.

Ports:
raw_clk  input  1  system clock; all logic on posedge.
reset_n  input  1  asynchronous, active-low reset.
start  input  1  transfer request; accepted only when busy=0.
data_tx  input  DATA_WIDTH  word to send; latched on accept.
clock_div  input  DIV_WIDTH  SCLK half-period = clock_div+1 raw_clk cycles; latched on accept.
cpol  input  1  SCLK idle level; latched on accept.
cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge; latched on accept.
lsb_first  input  1  shift order; latched on accept.
cs_select  input  max(1,$clog2(NUM_CS))  chip-select index; latched on accept.
hold_cs  input  1  keep CS asserted after this word; latched on accept.
data_rx  output  DATA_WIDTH  received word; updated only in the done cycle.
busy  output  1  high from the cycle after accept until the cycle done pulses, inclusive.
done  output  1  one-cycle pulse at end of transfer.
sclk  output  1  SPI clock.
mosi  output  1  SPI data out.
miso  input  1  SPI data in.
cs_n  output  NUM_CS  active-low chip selects; at most one bit low at any time.

Behaviour:
- Reset (async assert, sync deassert assumed upstream): state=IDLE, busy=0, done=0, sclk=0, mosi=0, cs_n all 1, data_rx=0, shift/bit/divider counters 0.
- Half-period tick: a divider counter runs 0..clock_div_latched; each wrap advances the FSM one phase. clock_div=0 gives SCLK = raw_clk/2.
- States:
  - IDLE: sclk tracks the live cpol input; mosi=0. On start: latch all config and data_tx, assert cs_n[cs_select], busy=1, go to SETUP.
  - SETUP: one half-period of CS lead time. If cpha=0, mosi is driven with the first bit on entry. On tick go to LEAD.
  - LEAD: sclk toggles to ~cpol. cpha=0: sample miso. cpha=1: drive the next bit on mosi. On tick go to TRAIL.
  - TRAIL: sclk returns to cpol. cpha=0: drive the next bit unless this was the last bit. cpha=1: sample miso. The bit counter increments. On tick, go to LEAD if bits remain, else to HOLD.
  - HOLD: one half-period of CS trail time. Then copy rx shift to data_rx, pulse done, set busy=0, and release CS unless hold_cs is set. Go to IDLE.
- Bit order: lsb_first=0 shifts MSB first and receives into the LSB. lsb_first=1 mirrors both directions.
- CS hold: while CS is held in IDLE, a start with the same cs_select skips CS re-assert but still spends SETUP.
- A start with a different cs_select releases the held CS in the accept cycle and asserts the new one in the next cycle; there is never overlap.
- start while busy=1 is ignored, with no queueing.
- Input changes during a transfer have no effect, because everything is latched.
- Exactly DATA_WIDTH LEAD/TRAIL pairs occur per transfer.
- reset_n asserted mid-transfer forces the reset values immediately; the partial rx word is discarded and no done pulse is issued.

Decomposition:
- Package spi_pkg holds:
  - the state enum (IDLE, SETUP, LEAD, TRAIL, HOLD);
  - a mode constant pair MODE0..MODE3 = {cpol,cpha}.
- One sub-module, spi_clock_div: the divider counter with tick output, reload on accept, cleared in IDLE.
- Shifter, bit counter and FSM stay in spi_master.

Test Plan:
- Mode 0, DATA_WIDTH=8, clock_div=0, tx=0xA5, miso looped to mosi: 8 sclk pulses; rx=0xA5; done pulses once; busy is high for 2+16+1 half-periods.
- Mode 3, clock_div=3, tx=0x3C, slave model returns 0xC3: sclk idles high with a period of 8 raw_clk cycles; miso is sampled on rising edges; rx=0xC3.
- lsb_first=1, mode 1, tx=0x01: the first mosi bit is 1 and the following seven are 0; rx is bit-reversed relative to the slave's MSB-first 0x80, giving 0x01.
- NUM_CS=4: word 1 with cs_select=2, hold_cs=1; word 2 with cs_select=2, hold_cs=0. cs_n stays 4'b1011 across both words and returns to 4'b1111 after the second done. A third word to cs 1 shows no cs overlap.
- Apply start while busy, plus changes to data_tx and cpol mid-transfer: the transfer is unaffected and the second start is dropped.
- Assert reset_n at bit 4 of a transfer: outputs go to reset values asynchronously with no done. A subsequent transfer of 0x5A completes correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      LEAD  = 3'd2,
      TRAIL = 3'd3,
      HOLD  = 3'd4
   } spi_state_t;

   // {cpol, cpha} encodings of the four SPI modes
   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_clock_div.sv
// SCLK half-period timer: a down-counter reloaded with the latched divider,
// ticking once every div+1 raw_clk cycles while a transfer is running.
module spi_clock_div #(
   parameter int DIV_WIDTH = 8
) (
   input  logic                 raw_clk,
   input  logic                 reset_n,
   input  logic                 load,
   input  logic                 run,
   input  logic [DIV_WIDTH-1:0] div_in,
   output logic                 tick
);

   logic [DIV_WIDTH-1:0] div_q;
   logic [DIV_WIDTH-1:0] cnt_q;

   assign tick = run && (cnt_q == '0);

   // Latch the divider on accept, then count down and reload on terminal count.
   always_ff @(posedge raw_clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q <= '0;
         cnt_q <= '0;
      end else if (load) begin
         div_q <= div_in;
         cnt_q <= div_in;
      end else if (!run) begin
         cnt_q <= '0;
      end else if (cnt_q == '0) begin
         cnt_q <= div_q;
      end else begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

endmodule

// File: rtl/spi_master.sv
// Parametrised SPI master: start/busy/done handshake on the bus side,
// sclk/mosi/miso/cs_n on the pin side.
//
// state | meaning
// IDLE  | sclk follows live cpol, waits for start
// SETUP | CS lead time, one half-period
// LEAD  | sclk at ~cpol (leading edge taken)
// TRAIL | sclk back at cpol (trailing edge taken)
// HOLD  | CS trail time, one half-period, then done
module spi_master
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DIV_WIDTH  = 8,
   parameter int NUM_CS     = 1,
   localparam int CSW       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic                  raw_clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] data_tx,
   input  logic [DIV_WIDTH-1:0]  clock_div,
   input  logic                  cpol,
   input  logic                  cpha,
   input  logic                  lsb_first,
   input  logic [CSW-1:0]        cs_select,
   input  logic                  hold_cs,
   output logic [DATA_WIDTH-1:0] data_rx,
   output logic                  busy,
   output logic                  done,
   output logic                  sclk,
   output logic                  mosi,
   input  logic                  miso,
   output logic [NUM_CS-1:0]     cs_n
);

   localparam int BCW = $clog2(DATA_WIDTH);

   spi_state_t            state_q, state_d;
   logic                  tick;
   logic                  accept;
   logic                  last_bit;
   logic                  cpol_q, cpha_q, lsb_q, hold_q;
   logic [CSW-1:0]        sel_q;
   logic [DATA_WIDTH-1:0] tx_sr, rx_sr;
   logic [BCW-1:0]        bit_cnt;

   function automatic logic out_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
      return lsb ? w[0] : w[DATA_WIDTH-1];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] shift_tx(input logic [DATA_WIDTH-1:0] w,
                                                      input logic lsb);
      return lsb ? (w >> 1) : (w << 1);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] shift_rx(input logic [DATA_WIDTH-1:0] w,
                                                      input logic b, input logic lsb);
      return lsb ? {b, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], b};
   endfunction

   // Active-low one-cold mask; an out-of-range index selects nothing.
   function automatic logic [NUM_CS-1:0] cs_mask(input logic [CSW-1:0] sel);
      return ~(NUM_CS'(1) << sel);
   endfunction

   assign accept   = (state_q == IDLE) && start && !busy;
   assign last_bit = (bit_cnt == BCW'(DATA_WIDTH - 1));

   spi_clock_div #(.DIV_WIDTH(DIV_WIDTH)) u_clock_div (
      .raw_clk (raw_clk),
      .reset_n (reset_n),
      .load    (accept),
      .run     (state_q != IDLE),
      .div_in  (clock_div),
      .tick    (tick)
   );

   // State register.
   always_ff @(posedge raw_clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic: every phase lasts exactly one divider tick.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = SETUP;
         SETUP:   if (tick)   state_d = LEAD;
         LEAD:    if (tick)   state_d = TRAIL;
         TRAIL:   if (tick)   state_d = last_bit ? HOLD : LEAD;
         HOLD:    if (tick)   state_d = IDLE;
         default:             state_d = IDLE;
      endcase
   end

   // Datapath: pin outputs, shifters, bit counter and handshake, all updated
   // on the tick that leaves a phase so edges line up with state entry.
   always_ff @(posedge raw_clk or negedge reset_n) begin
      if (!reset_n) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         sclk    <= 1'b0;
         mosi    <= 1'b0;
         cs_n    <= '1;
         data_rx <= '0;
         tx_sr   <= '0;
         rx_sr   <= '0;
         bit_cnt <= '0;
         cpol_q  <= 1'b0;
         cpha_q  <= 1'b0;
         lsb_q   <= 1'b0;
         hold_q  <= 1'b0;
         sel_q   <= '0;
      end else begin
         done <= 1'b0;
         case (state_q)
            IDLE: begin
               sclk <= cpol;
               mosi <= 1'b0;
               if (done) busy <= 1'b0;
               if (accept) begin
                  busy    <= 1'b1;
                  cpol_q  <= cpol;
                  cpha_q  <= cpha;
                  lsb_q   <= lsb_first;
                  hold_q  <= hold_cs;
                  sel_q   <= cs_select;
                  bit_cnt <= '0;
                  rx_sr   <= '0;
                  if (cpha) begin
                     tx_sr <= data_tx;
                  end else begin
                     mosi  <= out_bit(data_tx, lsb_first);
                     tx_sr <= shift_tx(data_tx, lsb_first);
                  end
                  // A held CS for another slave is dropped first; SETUP asserts the new one.
                  if (cs_n != cs_mask(cs_select))
                     cs_n <= (&cs_n) ? cs_mask(cs_select) : '1;
               end
            end
            SETUP: begin
               cs_n <= cs_mask(sel_q);
               if (tick) begin
                  sclk <= ~cpol_q;
                  if (cpha_q) begin
                     mosi  <= out_bit(tx_sr, lsb_q);
                     tx_sr <= shift_tx(tx_sr, lsb_q);
                  end
               end
            end
            LEAD: begin
               if (tick) begin
                  sclk <= cpol_q;
                  if (!cpha_q) begin
                     rx_sr <= shift_rx(rx_sr, miso, lsb_q);
                     if (!last_bit) begin
                        mosi  <= out_bit(tx_sr, lsb_q);
                        tx_sr <= shift_tx(tx_sr, lsb_q);
                     end
                  end
               end
            end
            TRAIL: begin
               if (tick) begin
                  if (cpha_q) rx_sr <= shift_rx(rx_sr, miso, lsb_q);
                  if (!last_bit) begin
                     bit_cnt <= bit_cnt + BCW'(1);
                     sclk    <= ~cpol_q;
                     if (cpha_q) begin
                        mosi  <= out_bit(tx_sr, lsb_q);
                        tx_sr <= shift_tx(tx_sr, lsb_q);
                     end
                  end
               end
            end
            HOLD: begin
               if (tick) begin
                  data_rx <= rx_sr;
                  done    <= 1'b1;
                  mosi    <= 1'b0;
                  if (!hold_q) cs_n <= '1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// Directed testbench for spi_master: loopback and slave-model transfers in all
// the interesting modes, CS hold/switch, busy protection and mid-transfer reset.
module tb_spi_master;
   import spi_pkg::*;

   logic       raw_clk   = 1'b0;
   logic       reset_n   = 1'b0;
   logic       start     = 1'b0;
   logic [7:0] data_tx   = 8'h00;
   logic [7:0] clock_div = 8'h00;
   logic       cpol      = 1'b0;
   logic       cpha      = 1'b0;
   logic       lsb_first = 1'b0;
   logic [1:0] cs_select = 2'd0;
   logic       hold_cs   = 1'b0;
   logic [7:0] data_rx;
   logic       busy, done, sclk, mosi;
   logic       miso;
   logic [3:0] cs_n;

   logic       loop_en = 1'b0;
   logic       miso_s  = 1'b0;
   assign miso = loop_en ? mosi : miso_s;

   spi_master #(.DATA_WIDTH(8), .DIV_WIDTH(8), .NUM_CS(4)) dut (
      .raw_clk   (raw_clk),
      .reset_n   (reset_n),
      .start     (start),
      .data_tx   (data_tx),
      .clock_div (clock_div),
      .cpol      (cpol),
      .cpha      (cpha),
      .lsb_first (lsb_first),
      .cs_select (cs_select),
      .hold_cs   (hold_cs),
      .data_rx   (data_rx),
      .busy      (busy),
      .done      (done),
      .sclk      (sclk),
      .mosi      (mosi),
      .miso      (miso),
      .cs_n      (cs_n)
   );

   always #5 raw_clk = ~raw_clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Event counters sampled away from the active edge.
   int done_cnt = 0, busy_cnt = 0, rise_cnt = 0, overlap_cnt = 0;
   always @(negedge raw_clk) begin
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      if ($countones(~cs_n) > 1) overlap_cnt++;
   end
   always @(posedge sclk) rise_cnt++;

   // SPI slave model: MSB-first, returns slv_tx, captures mosi into slv_rx.
   logic [7:0] slv_tx = 8'h00;
   logic       slv_cpol = 1'b0, slv_cpha = 1'b0;
   int         slv_gen = 0;
   logic [7:0] slv_rx = 8'h00;
   int         slv_idx = 0;
   int         last_gen = 0;
   always @(sclk or slv_gen) begin
      if (slv_gen != last_gen) begin
         last_gen = slv_gen;
         slv_rx   = 8'h00;
         slv_idx  = slv_cpha ? 0 : 1;
         miso_s   = slv_cpha ? 1'b0 : slv_tx[7];
      end else if (cs_n != 4'hF) begin
         if ((sclk != slv_cpol) != slv_cpha) begin
            slv_rx = {slv_rx[6:0], mosi};
         end else begin
            if (slv_idx < 8) miso_s = slv_tx[7 - slv_idx];
            slv_idx++;
         end
      end
   end

   task automatic set_cfg(input logic [7:0] tx, input logic [7:0] div, input logic [1:0] mode,
                          input logic lsb, input logic [1:0] sel, input logic hold);
      data_tx = tx; clock_div = div; {cpol, cpha} = mode;
      lsb_first = lsb; cs_select = sel; hold_cs = hold;
   endtask

   task automatic arm_slave(input logic [7:0] tx, input logic [1:0] mode);
      slv_tx = tx; {slv_cpol, slv_cpha} = mode; slv_gen++;
   endtask

   task automatic pulse_start;
      start = 1'b1;
      @(negedge raw_clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, output logic [7:0] rx);
      int n = 0;
      while (!done && n < 5000) begin
         @(negedge raw_clk);
         n++;
      end
      check({tag, "_done_seen"}, done, 1);
      rx = data_rx;
   endtask

   logic [7:0] rx;
   int b_done, b_busy, b_rise, b_ov;

   task automatic take_base;
      b_done = done_cnt; b_busy = busy_cnt; b_rise = rise_cnt;
   endtask

   initial begin
      repeat (3) @(negedge raw_clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sclk", sclk, 0);
      check("rst_mosi", mosi, 0);
      check("rst_cs_n", cs_n, 4'hF);
      check("rst_data_rx", data_rx, 0);
      reset_n = 1'b1;
      b_ov = overlap_cnt;

      // Mode 0, div 0, loopback
      set_cfg(8'hA5, 8'd0, MODE0, 1'b0, 2'd0, 1'b0);
      loop_en = 1'b1; arm_slave(8'h00, MODE0);
      repeat (2) @(negedge raw_clk);
      take_base();
      pulse_start();
      wait_done("m0", rx);
      check("m0_rx", rx, 8'hA5);
      repeat (3) @(negedge raw_clk); #1;
      check("m0_busy_len", busy_cnt - b_busy, 19);
      check("m0_done_cnt", done_cnt - b_done, 1);
      check("m0_sclk_pulses", rise_cnt - b_rise, 8);
      check("m0_slave_rx", slv_rx, 8'hA5);

      // Mode 3, div 3, slave returns 0xC3
      set_cfg(8'h3C, 8'd3, MODE3, 1'b0, 2'd0, 1'b0);
      loop_en = 1'b0; arm_slave(8'hC3, MODE3);
      repeat (3) @(negedge raw_clk);
      check("m3_sclk_idle", sclk, 1);
      take_base();
      pulse_start();
      wait_done("m3", rx);
      check("m3_rx", rx, 8'hC3);
      repeat (3) @(negedge raw_clk); #1;
      check("m3_busy_len", busy_cnt - b_busy, 73);
      check("m3_sclk_rises", rise_cnt - b_rise, 8);
      check("m3_slave_rx", slv_rx, 8'h3C);

      // LSB first, mode 1, div 1
      set_cfg(8'h01, 8'd1, MODE1, 1'b1, 2'd0, 1'b0);
      arm_slave(8'h80, MODE1);
      repeat (3) @(negedge raw_clk);
      take_base();
      pulse_start();
      wait_done("lsb", rx);
      check("lsb_rx", rx, 8'h01);
      repeat (3) @(negedge raw_clk); #1;
      check("lsb_busy_len", busy_cnt - b_busy, 37);
      check("lsb_slave_rx", slv_rx, 8'h80);

      // CS hold across two words on cs 2, then switch to cs 1
      set_cfg(8'h11, 8'd1, MODE0, 1'b0, 2'd2, 1'b1);
      loop_en = 1'b1; arm_slave(8'h00, MODE0);
      repeat (2) @(negedge raw_clk);
      pulse_start();
      repeat (6) @(negedge raw_clk);
      check("cs_w1_active", cs_n, 4'b1011);
      wait_done("cs_w1", rx);
      check("cs_w1_rx", rx, 8'h11);
      repeat (3) @(negedge raw_clk);
      check("cs_held_idle", cs_n, 4'b1011);
      set_cfg(8'h22, 8'd1, MODE0, 1'b0, 2'd2, 1'b0);
      pulse_start();
      check("cs_w2_setup", cs_n, 4'b1011);
      wait_done("cs_w2", rx);
      check("cs_w2_rx", rx, 8'h22);
      repeat (2) @(negedge raw_clk);
      check("cs_released", cs_n, 4'hF);
      set_cfg(8'h33, 8'd1, MODE0, 1'b0, 2'd2, 1'b1);
      pulse_start();
      wait_done("cs_w3", rx);
      repeat (2) @(negedge raw_clk);
      set_cfg(8'h44, 8'd1, MODE0, 1'b0, 2'd1, 1'b0);
      pulse_start();
      check("cs_switch_release", cs_n, 4'hF);
      @(negedge raw_clk);
      check("cs_switch_new", cs_n, 4'b1101);
      wait_done("cs_w4", rx);
      check("cs_w4_rx", rx, 8'h44);
      repeat (2) @(negedge raw_clk); #1;
      check("cs_no_overlap", overlap_cnt - b_ov, 0);

      // start while busy and live input changes are ignored
      set_cfg(8'h96, 8'd2, MODE0, 1'b0, 2'd0, 1'b0);
      arm_slave(8'h00, MODE0);
      repeat (2) @(negedge raw_clk);
      take_base();
      pulse_start();
      repeat (10) @(negedge raw_clk);
      data_tx = 8'hFF; cpol = 1'b1;
      pulse_start();
      data_tx = 8'h00;
      wait_done("busy", rx);
      check("busy_rx", rx, 8'h96);
      repeat (4) @(negedge raw_clk); #1;
      check("busy_done_cnt", done_cnt - b_done, 1);
      check("busy_len", busy_cnt - b_busy, 55);
      check("busy_slave_rx", slv_rx, 8'h96);
      cpol = 1'b0;
      repeat (3) @(negedge raw_clk);

      // reset at bit 4, then a clean transfer
      set_cfg(8'hF0, 8'd1, MODE0, 1'b0, 2'd0, 1'b0);
      arm_slave(8'h00, MODE0);
      repeat (2) @(negedge raw_clk);
      take_base();
      pulse_start();
      begin
         int n = 0;
         while ((rise_cnt - b_rise) < 4 && n < 500) begin
            @(negedge raw_clk);
            n++;
         end
         check("rst_reached_bit4", ((rise_cnt - b_rise) >= 4) ? 1 : 0, 1);
      end
      #2 reset_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_sclk", sclk, 0);
      check("midrst_mosi", mosi, 0);
      check("midrst_cs_n", cs_n, 4'hF);
      check("midrst_data_rx", data_rx, 0);
      repeat (3) @(negedge raw_clk);
      reset_n = 1'b1;
      repeat (3) @(negedge raw_clk); #1;
      check("midrst_no_done", done_cnt - b_done, 0);
      set_cfg(8'h5A, 8'd1, MODE0, 1'b0, 2'd0, 1'b0);
      arm_slave(8'h00, MODE0);
      @(negedge raw_clk);
      pulse_start();
      wait_done("post", rx);
      check("post_rx", rx, 8'h5A);
      check("post_slave_rx", slv_rx, 8'h5A);

      repeat (3) @(negedge raw_clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
